// File: rtl/datapath_controller.sv
// Multi-cycle control FSM sequencing fetch/decode/execute/memory/write-back for a simple ARM-subset datapath.
// Latency: 5 cycles for data-processing, 7 for LDR, 4 for B, 3 for a condition-failed or unsupported instruction.
// Backpressure: none; instruction and data memory have a fixed 1-cycle read latency, so there are no handshake inputs.
module datapath_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic [3:0]  flags,
  input  logic [31:0] alu_result,
  output logic [31:0] pc,
  output logic        instr_rd,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [2:0]  state,
  output logic [3:0]  A_addr,
  output logic [3:0]  B_addr,
  output logic [3:0]  shift_addr,
  output logic [3:0]  w_addr1,
  output logic        en_A,
  output logic        en_B,
  output logic        en_S,
  output logic        sel_shift,
  output logic        sel_A,
  output logic        sel_B,
  output logic        sel_post_shift,
  output logic        en_status,
  output logic        w_en1,
  output logic        sel_w_data,
  output logic [1:0]  shift_op,
  output logic [2:0]  ALU_op,
  output logic [31:0] shift_imme,
  output logic [31:0] imme_data
);

  localparam logic [2:0] FETCH       = 3'd0;
  localparam logic [2:0] FETCH_WAIT  = 3'd1;
  localparam logic [2:0] DECODE      = 3'd2;
  localparam logic [2:0] EXECUTE     = 3'd3;
  localparam logic [2:0] MEMORY      = 3'd4;
  localparam logic [2:0] MEMORY_WAIT = 3'd5;
  localparam logic [2:0] WRITE_BACK  = 3'd6;

  logic [31:0] ir;
  logic [2:0]  next_state;

  // Instruction-class decode, all taken from the latched instruction word.
  logic [3:0]  opcode;
  logic        is_dp, is_ldr, is_b, is_cmp, is_mov;
  logic        dp_ok, cond_pass, supported;
  logic [2:0]  dp_alu_op;
  logic [4:0]  rot_amt;
  logic [31:0] imm8_ext, imm_rot, br_off;

  assign opcode   = ir[24:21];
  assign is_dp    = (ir[27:26] == 2'b00);
  assign is_ldr   = (ir[27:26] == 2'b01) && ir[20] && !ir[25];
  assign is_b     = (ir[27:25] == 3'b101);
  assign is_cmp   = is_dp && (opcode == 4'b1010);
  assign is_mov   = is_dp && (opcode == 4'b1101);
  assign supported = (is_dp && dp_ok) || is_ldr || is_b;

  // Rotated immediate: zero-extended imm8 rotated right by twice the 4-bit rotate field.
  // A shift by 32 yields 0, so a rotate of 0 falls out of the same expression.
  assign rot_amt  = {ir[11:8], 1'b0};
  assign imm8_ext = {24'd0, ir[7:0]};
  assign imm_rot  = (imm8_ext >> rot_amt) | (imm8_ext << (6'd32 - {1'b0, rot_amt}));

  // Branch displacement in bytes: sign-extended word offset.
  assign br_off   = {{6{ir[23]}}, ir[23:0], 2'b00};

  // Map supported data-processing opcodes to ALU operations; anything else is rejected at DECODE.
  always_comb begin
    dp_ok     = 1'b1;
    dp_alu_op = 3'b000;
    case (opcode)
      4'b0000: dp_alu_op = 3'b010;  // AND
      4'b0001: dp_alu_op = 3'b100;  // EOR
      4'b0010: dp_alu_op = 3'b001;  // SUB
      4'b0100: dp_alu_op = 3'b000;  // ADD
      4'b1010: dp_alu_op = 3'b001;  // CMP
      4'b1100: dp_alu_op = 3'b011;  // ORR
      4'b1101: dp_alu_op = 3'b000;  // MOV (operand A bypassed via sel_A)
      default: dp_ok     = 1'b0;
    endcase
  end

  // Condition-code check against live NZCV flags (N=3, Z=2, C=1, V=0).
  always_comb begin
    cond_pass = 1'b0;
    case (ir[31:28])
      4'b0000: cond_pass = flags[2];
      4'b0001: cond_pass = !flags[2];
      4'b0010: cond_pass = flags[1];
      4'b0011: cond_pass = !flags[1];
      4'b0100: cond_pass = flags[3];
      4'b0101: cond_pass = !flags[3];
      4'b0110: cond_pass = flags[0];
      4'b0111: cond_pass = !flags[0];
      4'b1000: cond_pass = flags[1] && !flags[2];
      4'b1001: cond_pass = !flags[1] || flags[2];
      4'b1010: cond_pass = (flags[3] == flags[0]);
      4'b1011: cond_pass = (flags[3] != flags[0]);
      4'b1100: cond_pass = !flags[2] && (flags[3] == flags[0]);
      4'b1101: cond_pass = flags[2] || (flags[3] != flags[0]);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Next-state selection; the spare encoding recovers to FETCH.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:       next_state = FETCH_WAIT;
      FETCH_WAIT:  next_state = DECODE;
      DECODE:      next_state = (cond_pass && supported) ? EXECUTE : FETCH;
      EXECUTE: begin
        if (is_ldr)                next_state = MEMORY;
        else if (is_b || is_cmp)   next_state = FETCH;
        else                       next_state = WRITE_BACK;
      end
      MEMORY:      next_state = MEMORY_WAIT;
      MEMORY_WAIT: next_state = WRITE_BACK;
      WRITE_BACK:  next_state = FETCH;
      default:     next_state = FETCH;
    endcase
  end

  // State register; reset drops any in-flight instruction back to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  // Architectural registers: instruction latch, program counter, load address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= 32'd0;
      ir       <= 32'd0;
      mem_addr <= 32'd0;
    end else begin
      if (state == FETCH_WAIT) begin
        ir <= instr_in;
        pc <= pc + 32'd4;
      end else if (state == EXECUTE) begin
        if (is_b)   pc       <= pc + 32'd4 + br_off;
        if (is_ldr) mem_addr <= alu_result;
      end
    end
  end

  // Memory strobes; the fetch strobe is held off while reset is asserted.
  assign instr_rd       = (state == FETCH) && rst_n;
  assign mem_rd         = (state == MEMORY);
  assign sel_post_shift = 1'b0;

  // Datapath controls: everything defaults to 0 and is driven only by the state/class that owns it.
  always_comb begin
    A_addr     = 4'd0;
    B_addr     = 4'd0;
    shift_addr = 4'd0;
    w_addr1    = 4'd0;
    en_A       = 1'b0;
    en_B       = 1'b0;
    en_S       = 1'b0;
    sel_shift  = 1'b0;
    sel_A      = 1'b0;
    sel_B      = 1'b0;
    en_status  = 1'b0;
    w_en1      = 1'b0;
    sel_w_data = 1'b0;
    shift_op   = 2'b00;
    ALU_op     = 3'b000;
    shift_imme = 32'd0;
    imme_data  = 32'd0;
    case (state)
      DECODE: begin
        A_addr     = ir[19:16];
        B_addr     = ir[3:0];
        shift_addr = ir[11:8];
        shift_op   = ir[6:5];
        shift_imme = {27'd0, ir[11:7]};
        sel_shift  = ir[4];
        if (cond_pass && supported) begin
          en_A = 1'b1;
          en_B = 1'b1;
          en_S = 1'b1;
        end
      end
      EXECUTE, WRITE_BACK: begin
        if (is_dp) begin
          // ALU controls are held unchanged through WRITE_BACK so the result stays stable while written.
          ALU_op = dp_alu_op;
          sel_A  = is_mov;
          sel_B  = ir[25];
          if (ir[25]) begin
            imme_data = imm_rot;
          end else begin
            shift_op   = ir[6:5];
            shift_imme = {27'd0, ir[11:7]};
            sel_shift  = ir[4];
          end
          if (state == EXECUTE) begin
            en_status = ir[20] || is_cmp;
          end else begin
            w_en1   = 1'b1;
            w_addr1 = ir[15:12];
          end
        end else if (is_ldr) begin
          if (state == EXECUTE) begin
            sel_B     = 1'b1;
            imme_data = {20'd0, ir[11:0]};
            ALU_op    = ir[23] ? 3'b000 : 3'b001;
          end else begin
            w_en1      = 1'b1;
            sel_w_data = 1'b1;
            w_addr1    = ir[15:12];
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller: small instruction ROM model, checks sampled on the falling edge.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_datapath_controller;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_in;
  logic [3:0]  flags;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic        instr_rd;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [2:0]  state;
  logic [3:0]  A_addr, B_addr, shift_addr, w_addr1;
  logic        en_A, en_B, en_S, sel_shift, sel_A, sel_B, sel_post_shift;
  logic        en_status, w_en1, sel_w_data;
  logic [1:0]  shift_op;
  logic [2:0]  ALU_op;
  logic [31:0] shift_imme, imme_data;

  logic [31:0] imem [0:15];
  int n_cmp;
  int n_bad;

  datapath_controller dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .flags(flags), .alu_result(alu_result),
    .pc(pc), .instr_rd(instr_rd), .mem_addr(mem_addr), .mem_rd(mem_rd), .state(state),
    .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr), .w_addr1(w_addr1),
    .en_A(en_A), .en_B(en_B), .en_S(en_S), .sel_shift(sel_shift), .sel_A(sel_A), .sel_B(sel_B),
    .sel_post_shift(sel_post_shift), .en_status(en_status), .w_en1(w_en1), .sel_w_data(sel_w_data),
    .shift_op(shift_op), .ALU_op(ALU_op), .shift_imme(shift_imme), .imme_data(imme_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: word appears one cycle after the read strobe.
  initial instr_in = 32'd0;
  always @(posedge clk) if (instr_rd) instr_in <= imem[pc[5:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 16; i++) imem[i] = 32'd0;
    imem[0] = 32'hE2821005;  // ADD R1,R2,#5
    imem[1] = 32'h03A004FF;  // MOVEQ R0,#0xFF000000 (Z=0 -> skipped)
    imem[2] = 32'h03A004FF;  // MOVEQ R0,#0xFF000000 (Z=1 -> executed)
    imem[3] = 32'hE1530004;  // CMP R3,R4
    imem[4] = 32'hEAFFFFFE;  // B -2
    rst_n      = 1'b0;
    flags      = 4'b0000;
    alu_result = 32'd0;

    // Reset state
    #3;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr_rd", {31'd0, instr_rd}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_w_en1", {31'd0, w_en1}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("rel_instr_rd", {31'd0, instr_rd}, 32'd1);

    // ADD R1,R2,#5
    step(); chk("add_fw_state", {29'd0, state}, 32'd1);
    step(); chk("add_dec_state", {29'd0, state}, 32'd2);
    chk("add_dec_pc", pc, 32'd4);
    chk("add_dec_en_A", {31'd0, en_A}, 32'd1);
    chk("add_dec_A_addr", {28'd0, A_addr}, 32'd2);
    chk("add_dec_B_addr", {28'd0, B_addr}, 32'd5);
    step(); chk("add_ex_state", {29'd0, state}, 32'd3);
    chk("add_ex_w_en1", {31'd0, w_en1}, 32'd0);
    chk("add_ex_en_status", {31'd0, en_status}, 32'd0);
    step(); chk("add_wb_state", {29'd0, state}, 32'd6);
    chk("add_wb_w_en1", {31'd0, w_en1}, 32'd1);
    chk("add_wb_w_addr1", {28'd0, w_addr1}, 32'd1);
    chk("add_wb_sel_B", {31'd0, sel_B}, 32'd1);
    chk("add_wb_imme", imme_data, 32'd5);
    chk("add_wb_alu_op", {29'd0, ALU_op}, 32'd0);
    chk("add_wb_sel_w_data", {31'd0, sel_w_data}, 32'd0);
    step(); chk("add_done_state", {29'd0, state}, 32'd0);
    chk("add_done_pc", pc, 32'd4);

    // MOVEQ with Z=0: dropped at DECODE
    step(); step();
    chk("moveq0_dec_state", {29'd0, state}, 32'd2);
    chk("moveq0_dec_en_A", {31'd0, en_A}, 32'd0);
    step(); chk("moveq0_next_state", {29'd0, state}, 32'd0);
    chk("moveq0_w_en1", {31'd0, w_en1}, 32'd0);
    chk("moveq0_pc", pc, 32'd8);

    // MOVEQ with Z=1: executes
    flags = 4'b0100;
    step(); step();
    chk("moveq1_dec_en_B", {31'd0, en_B}, 32'd1);
    step(); chk("moveq1_ex_state", {29'd0, state}, 32'd3);
    chk("moveq1_ex_imme", imme_data, 32'hFF000000);
    chk("moveq1_ex_sel_A", {31'd0, sel_A}, 32'd1);
    chk("moveq1_ex_sel_B", {31'd0, sel_B}, 32'd1);
    step(); chk("moveq1_wb_w_en1", {31'd0, w_en1}, 32'd1);
    chk("moveq1_wb_w_addr1", {28'd0, w_addr1}, 32'd0);
    chk("moveq1_wb_en_status", {31'd0, en_status}, 32'd0);
    step(); chk("moveq1_done_pc", pc, 32'h0000000C);

    // CMP R3,R4
    step(); step();
    chk("cmp_dec_A_addr", {28'd0, A_addr}, 32'd3);
    chk("cmp_dec_B_addr", {28'd0, B_addr}, 32'd4);
    step(); chk("cmp_ex_state", {29'd0, state}, 32'd3);
    chk("cmp_ex_en_status", {31'd0, en_status}, 32'd1);
    chk("cmp_ex_alu_op", {29'd0, ALU_op}, 32'd1);
    chk("cmp_ex_w_en1", {31'd0, w_en1}, 32'd0);
    step(); chk("cmp_next_state", {29'd0, state}, 32'd0);
    chk("cmp_next_w_en1", {31'd0, w_en1}, 32'd0);
    chk("cmp_next_pc", pc, 32'h00000010);

    // B -2 at 0x10 loops back to 0x10
    step(); step();
    chk("b_dec_pc", pc, 32'h00000014);
    step(); chk("b_ex_state", {29'd0, state}, 32'd3);
    chk("b_ex_w_en1", {31'd0, w_en1}, 32'd0);
    step(); chk("b_next_state", {29'd0, state}, 32'd0);
    chk("b_target_pc", pc, 32'h00000010);

    // LDR R5,[R6,#8] fetched from 0x10
    imem[4]    = 32'hE5965008;
    imem[5]    = 32'hE5965008;
    alu_result = 32'h00000108;
    step(); step();
    chk("ldr_dec_A_addr", {28'd0, A_addr}, 32'd6);
    step(); chk("ldr_ex_state", {29'd0, state}, 32'd3);
    chk("ldr_ex_sel_B", {31'd0, sel_B}, 32'd1);
    chk("ldr_ex_sel_A", {31'd0, sel_A}, 32'd0);
    chk("ldr_ex_imme", imme_data, 32'd8);
    chk("ldr_ex_alu_op", {29'd0, ALU_op}, 32'd0);
    step(); chk("ldr_mem_state", {29'd0, state}, 32'd4);
    chk("ldr_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("ldr_mem_addr", mem_addr, 32'h00000108);
    step(); chk("ldr_mw_state", {29'd0, state}, 32'd5);
    chk("ldr_mw_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("ldr_mw_w_en1", {31'd0, w_en1}, 32'd0);
    step(); chk("ldr_wb_state", {29'd0, state}, 32'd6);
    chk("ldr_wb_w_en1", {31'd0, w_en1}, 32'd1);
    chk("ldr_wb_w_addr1", {28'd0, w_addr1}, 32'd5);
    chk("ldr_wb_sel_w_data", {31'd0, sel_w_data}, 32'd1);
    step(); chk("ldr_done_state", {29'd0, state}, 32'd0);
    chk("ldr_done_pc", pc, 32'h00000014);

    // Second LDR, reset asserted during MEMORY_WAIT
    repeat (5) step();
    chk("rst2_pre_state", {29'd0, state}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_state", {29'd0, state}, 32'd0);
    chk("rst2_pc", pc, 32'd0);
    chk("rst2_mem_addr", mem_addr, 32'd0);
    chk("rst2_w_en1", {31'd0, w_en1}, 32'd0);
    chk("rst2_instr_rd", {31'd0, instr_rd}, 32'd0);
    step(); chk("rst2_hold_w_en1", {31'd0, w_en1}, 32'd0);
    chk("rst2_hold_state", {29'd0, state}, 32'd0);

    // Unsupported opcode (ADC) is dropped at DECODE
    imem[0] = 32'hE0A12003;
    rst_n = 1'b1;
    #1;
    chk("rel2_instr_rd", {31'd0, instr_rd}, 32'd1);
    step(); step();
    chk("adc_dec_en_A", {31'd0, en_A}, 32'd0);
    chk("adc_dec_post_shift", {31'd0, sel_post_shift}, 32'd0);
    step(); chk("adc_next_state", {29'd0, state}, 32'd0);
    chk("adc_next_pc", pc, 32'd4);
    chk("adc_next_w_en1", {31'd0, w_en1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/datapath_controller.md
DATAPATH_CONTROLLER -- requirements
Module: datapath_controller

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL provide: instr_in  input  32  instruction word from memory, valid one cycle after instr_rd.
REQ-004 SHALL provide: flags  input  4  NZCV from datapath status_out[31:28].
REQ-005 SHALL provide: alu_result  input  32  datapath_out.
REQ-006 SHALL provide: ram_data_valid-free memory model, fixed 1-cycle read latency; no handshake inputs.
REQ-007 SHALL provide: pc  output  32  program counter; instr_rd  output  1  instruction read strobe.
REQ-008 SHALL provide: mem_addr  output  32  latched load address; mem_rd  output  1  data read strobe.
REQ-009 SHALL provide: state  output  3  current FSM state.
REQ-010 SHALL provide: A_addr, B_addr, shift_addr, w_addr1  output  4 each  register-file addresses.
REQ-011 SHALL provide: en_A, en_B, en_S, sel_shift, sel_A, sel_B, sel_post_shift, en_status, w_en1, sel_w_data  output  1 each  datapath controls.
REQ-012 SHALL provide: shift_op  output  2; ALU_op  output  3; shift_imme, imme_data  output  32.

Function
REQ-013 States, encoding: FETCH=0, FETCH_WAIT=1, DECODE=2, EXECUTE=3, MEMORY=4, MEMORY_WAIT=5, WRITE_BACK=6; unused encodings go to FETCH next cycle.
REQ-014 FETCH: instr_rd=1, next FETCH_WAIT.
REQ-015 FETCH_WAIT: ir <= instr_in, pc <= pc+4, next DECODE.
REQ-016 DECODE: cond ir[31:28] evaluated vs flags (EQ..LE standard ARM, 1110 always, 1111 never); fail or unsupported class -> FETCH; else en_A=1, en_B=1, en_S=1, next EXECUTE.
REQ-017 DECODE addressing: A_addr=ir[19:16]; B_addr=ir[3:0]; shift_addr=ir[11:8]; shift_op=ir[6:5]; shift_imme=ir[11:7] zero-extended; sel_shift=ir[4].
REQ-018 Data-processing (ir[27:26]=00) opcode->ALU_op: AND 0000->010, EOR 0001->100, SUB 0010->001, ADD 0100->000, CMP 1010->001, ORR 1100->011, MOV 1101->000 with sel_A=1; any other opcode unsupported.
REQ-019 Immediate form (ir[25]=1): sel_B=1, imme_data = ir[7:0] zero-extended rotated right by 2*ir[11:8]; else sel_B=0.
REQ-020 EXECUTE, data-processing: ALU controls driven from ir; en_status=1 if ir[20]=1 or CMP; CMP -> FETCH, else WRITE_BACK.
REQ-021 WRITE_BACK, data-processing: same ALU controls held, w_en1=1, w_addr1=ir[15:12], sel_w_data=0, en_status=0; next FETCH.
REQ-022 LDR (ir[27:26]=01, ir[20]=1, ir[25]=0): EXECUTE sel_A=0, sel_B=1, imme_data=ir[11:0] zero-extended, ALU_op=000 if ir[23]=1 else 001; mem_addr <= alu_result at EXECUTE edge; next MEMORY.
REQ-023 MEMORY: mem_rd=1, next MEMORY_WAIT; MEMORY_WAIT next WRITE_BACK; WRITE_BACK for LDR: w_en1=1, sel_w_data=1, w_addr1=ir[15:12].
REQ-024 Branch B (ir[27:25]=101): EXECUTE pc <= pc + 4 + (sign-extended ir[23:0] << 2), 32-bit wrap; next FETCH.
REQ-025 All datapath control outputs SHALL be 0 in any state/instruction not explicitly driving them; w_en1 and en_status never asserted outside REQ-020/021/023.
REQ-026 sel_post_shift SHALL be 0 always (reserved).
REQ-027 pc wraps 0xFFFFFFFC+4 -> 0x00000000.

Reset
REQ-028 rst_n=0 SHALL immediately force state=FETCH, pc=0, ir=0, mem_addr=0, all outputs 0 except state-derived strobes; instr_rd=1 only after rst_n deasserts.
REQ-029 Reset mid-instruction SHALL abandon it with no register write or flag update.

Verification
REQ-030 ADD R1,R2,#5 (0xE2821005): FETCH..WRITE_BACK in 5 cycles; WRITE_BACK w_en1=1, w_addr1=1, sel_B=1, imme_data=5, ALU_op=000; pc=4.
REQ-031 MOVEQ R0,#0xFF000000 (imm8=0xFF, rot=4) with flags Z=0: DECODE->FETCH, no w_en1; with Z=1 imme_data=0xFF000000, sel_A=1.
REQ-032 CMPS R3,R4 (0xE1530004): EXECUTE en_status=1, ALU_op=001, next FETCH, w_en1 never 1.
REQ-033 LDR R5,[R6,#8] with alu_result=0x108: mem_addr=0x108, mem_rd one cycle, WRITE_BACK w_addr1=5, sel_w_data=1; 7 cycles total.
REQ-034 B -2 (0xEAFFFFFE) at pc=0x10: next fetch pc=0x10.
REQ-035 rst_n low during MEMORY_WAIT: state=FETCH, pc=0 asynchronously, no w_en1 pulse.
